tile_tag_reader: RTL and testbench
==================================

TILE_TAG_READER -- requirements
Module: tile_tag_reader

Interface
REQ-001 The block SHALL have one clock and synchronous, active-high reset: clock, reset.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 start  input  1  one-cycle pulse that begins a scan of one 32x32 tile tag buffer.
REQ-005 tile_x / tile_y  input  6 each  tile coordinates, latched on accepted start.
REQ-006 busy  output  1  high from the cycle after an accepted start until done.
REQ-007 done  output  1  one-cycle pulse at scan completion.
REQ-008 tag_rd  output  1  tag RAM read strobe.
REQ-009 tag_rd_addr  output  10  pixel index, {y[4:0], x[4:0]}.
REQ-010 tag_rd_data  input  32  polygon tag, valid the cycle after tag_rd; 0 means no polygon.
REQ-011 span_valid / span_ready  output / input  1 each  span handshake; transfer when both are high on a clock edge.
REQ-012 span_poly_addr  output  32  tag value shared by the span.
REQ-013 span_x / span_y  output  5 each  start pixel of the span within the tile.
REQ-014 span_len  output  6  span length, 1..32.
REQ-015 span_tile_x / span_tile_y  output  6 each  latched tile coordinates.

Function
REQ-016 States: IDLE, SCAN, FLUSH, DONE.
- IDLE -> SCAN on start.
- start is ignored when not in IDLE.
REQ-017 SCAN read order:
- Reads pixels 0..1023 in row-major order, one read per cycle, unless stalled.
- tag_rd_addr increments by 1 per issued read; it is held while stalled.
REQ-018 Stall condition: span_valid=1 and span_ready=0.
- While stalled, tag_rd SHALL be 0.
- A read already in flight SHALL have its data captured in a one-entry hold register.
- That held data is consumed before any new data on resume.
- No pixel is dropped or read twice.
REQ-019 Run merging:
- Consecutive pixels in the same row with equal nonzero tags form one run.
- A run ends on a tag change, on a zero tag, or at x=31.
- Runs never cross rows.
REQ-020 Zero-tag pixels SHALL produce no span.
REQ-021 Span emission:
- A completed run loads the span registers and raises span_valid.
- Fields are poly tag, start x, y, len and tile coordinates.
REQ-022 All span_* outputs SHALL be stable while span_valid=1 and span_ready=0.
- span_valid SHALL drop in the cycle after a handshake unless a new span is loaded in that cycle.
REQ-023 Spans SHALL be emitted in row-major order of their start pixel.
REQ-024 Throughput: with span_ready held at 1, one pixel is processed per cycle.
- An all-zero tile SHALL complete with done exactly 2 cycles after the 1024th tag_rd.
REQ-025 SCAN -> FLUSH after the read of pixel 1023 is issued.
- FLUSH waits for the last data word, emits any final span, and waits for its handshake.
- FLUSH -> DONE when nothing is pending.
REQ-026 DONE:
- done=1 for exactly one cycle; busy=0 in that same cycle.
- DONE -> IDLE on the next cycle.
REQ-027 span_len SHALL be 32 for a full-row run and SHALL never be 0.
REQ-028 Simultaneous events:
- A span handshake and a new run completion in the same cycle SHALL load the new span with no bubble.
- reset has priority over all inputs.

Reset
REQ-029 While reset=1 at a clock edge, the block SHALL enter IDLE and clear the scan counter, hold register and run state.
- busy, done, tag_rd, span_valid = 0.
- tag_rd_addr, span_* = 0.
REQ-030 reset asserted mid-scan SHALL abort the scan with no done pulse and no further span.
- start is accepted on the first cycle after reset deasserts.

Verification
REQ-031 All-zero tile, span_ready=1:
- Exactly 1024 tag_rd cycles with addresses 0..1023.
- No span.
- done pulses once, 2 cycles after the last read.
REQ-032 Every tag = 0x00001000:
- Exactly 32 spans, each poly=0x00001000, x=0, len=32, with y=0..31 in order.
REQ-033 Row 5 pattern: x0-3 = A, x4 = 0, x5-9 = A, x10-31 = B; other rows 0.
- Spans in order: (A,x0,y5,len4), (A,x5,y5,len5), (B,x10,y5,len22).
REQ-034 Checkerboard A/B, random span_ready (about 30% high):
- 1024 spans of len 1 in order.
- Fields stable under stall.
- No tag_rd while stalled.
- Same sequence as with span_ready=1.
REQ-035 reset for one cycle while tag_rd_addr=300:
- Next cycle busy=0, span_valid=0, and no done.
- A following start with pattern REQ-033 produces exactly the REQ-033 spans.
REQ-036 A second start pulse during SCAN is ignored.
- The span sequence is unchanged and done pulses exactly once.

Source files
------------

// File: rtl/tile_tag_reader.sv
// Scans a 32x32 tile tag buffer in row-major order and merges equal nonzero
// tags within a row into spans, presented on a valid/ready handshake.
module tile_tag_reader (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  tile_x,
  input  logic [5:0]  tile_y,
  output logic        busy,
  output logic        done,
  output logic        tag_rd,
  output logic [9:0]  tag_rd_addr,
  input  logic [31:0] tag_rd_data,
  output logic        span_valid,
  input  logic        span_ready,
  output logic [31:0] span_poly_addr,
  output logic [4:0]  span_x,
  output logic [4:0]  span_y,
  output logic [5:0]  span_len,
  output logic [5:0]  span_tile_x,
  output logic [5:0]  span_tile_y
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state, state_next;
  logic [9:0]  rd_addr, rd_addr_next;
  logic        rd_pend, rd_pend_next;
  logic        hold_valid, hold_valid_next;
  logic [31:0] hold_data, hold_data_next;
  logic [9:0]  proc_cnt, proc_cnt_next;
  logic        proc_done, proc_done_next;
  logic        run_active, run_active_next;
  logic [31:0] run_tag, run_tag_next;
  logic [4:0]  run_x, run_x_next;
  logic [4:0]  run_y, run_y_next;
  logic [5:0]  run_len, run_len_next;
  logic [5:0]  tx, tx_next;
  logic [5:0]  ty, ty_next;
  logic        sp_valid, sp_valid_next;
  logic [31:0] sp_poly, sp_poly_next;
  logic [4:0]  sp_x, sp_x_next;
  logic [4:0]  sp_y, sp_y_next;
  logic [5:0]  sp_len, sp_len_next;

  logic        stall, rd, pix_vld, brk, load;
  logic [31:0] pix;
  logic [4:0]  pix_x, pix_y;

  // Next-state, read issue, run merging and span loading.
  always_comb begin
    state_next      = state;
    rd_addr_next    = rd_addr;
    rd_pend_next    = 1'b0;
    hold_valid_next = hold_valid;
    hold_data_next  = hold_data;
    proc_cnt_next   = proc_cnt;
    proc_done_next  = proc_done;
    run_active_next = run_active;
    run_tag_next    = run_tag;
    run_x_next      = run_x;
    run_y_next      = run_y;
    run_len_next    = run_len;
    tx_next         = tx;
    ty_next         = ty;
    sp_valid_next   = sp_valid;
    sp_poly_next    = sp_poly;
    sp_x_next       = sp_x;
    sp_y_next       = sp_y;
    sp_len_next     = sp_len;
    rd              = 1'b0;
    load            = 1'b0;

    stall   = sp_valid && !span_ready;
    pix_vld = !stall && (hold_valid || rd_pend);
    pix     = hold_valid ? hold_data : tag_rd_data;
    pix_x   = proc_cnt[4:0];
    pix_y   = proc_cnt[9:5];
    // A run is closed by the first pixel that cannot extend it, including the
    // first pixel of the next row, so at most one span is produced per pixel.
    brk     = run_active && ((pix == 32'd0) || (pix != run_tag) || (pix_x == 5'd0));

    if (sp_valid && span_ready) begin
      sp_valid_next = 1'b0;
    end else begin
      sp_valid_next = sp_valid;
    end

    case (state)
      IDLE: begin
        if (start) begin
          state_next      = SCAN;
          rd_addr_next    = 10'd0;
          hold_valid_next = 1'b0;
          proc_cnt_next   = 10'd0;
          proc_done_next  = 1'b0;
          run_active_next = 1'b0;
          tx_next         = tile_x;
          ty_next         = tile_y;
        end else begin
          state_next = IDLE;
        end
      end
      SCAN, FLUSH: begin
        rd           = (state == SCAN) && !stall;
        rd_pend_next = rd;
        if (rd) begin
          if (rd_addr == 10'd1023) begin
            state_next = FLUSH;
          end else begin
            rd_addr_next = rd_addr + 10'd1;
          end
        end else begin
          rd_addr_next = rd_addr;
        end

        if (stall && rd_pend) begin
          hold_valid_next = 1'b1;
          hold_data_next  = tag_rd_data;
        end else begin
          hold_data_next = hold_data;
        end

        if (pix_vld) begin
          hold_valid_next = 1'b0;
          proc_cnt_next   = proc_cnt + 10'd1;
          proc_done_next  = (proc_cnt == 10'd1023);
          load            = brk;
          if (pix == 32'd0) begin
            run_active_next = 1'b0;
          end else if (run_active && !brk) begin
            run_len_next = run_len + 6'd1;
          end else begin
            run_active_next = 1'b1;
            run_tag_next    = pix;
            run_x_next      = pix_x;
            run_y_next      = pix_y;
            run_len_next    = 6'd1;
          end
        end else if ((state == FLUSH) && proc_done && run_active && !stall) begin
          load            = 1'b1;
          run_active_next = 1'b0;
        end else begin
          load = 1'b0;
        end

        if (load) begin
          sp_valid_next = 1'b1;
          sp_poly_next  = run_tag;
          sp_x_next     = run_x;
          sp_y_next     = run_y;
          sp_len_next   = run_len;
        end else begin
          sp_poly_next = sp_poly;
        end

        if ((state == FLUSH) && proc_done_next && !run_active_next && !sp_valid_next) begin
          state_next = DONE;
        end else begin
          state_next = state_next;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      rd_addr    <= 10'd0;
      rd_pend    <= 1'b0;
      hold_valid <= 1'b0;
      hold_data  <= 32'd0;
      proc_cnt   <= 10'd0;
      proc_done  <= 1'b0;
      run_active <= 1'b0;
      run_tag    <= 32'd0;
      run_x      <= 5'd0;
      run_y      <= 5'd0;
      run_len    <= 6'd0;
      tx         <= 6'd0;
      ty         <= 6'd0;
      sp_valid   <= 1'b0;
      sp_poly    <= 32'd0;
      sp_x       <= 5'd0;
      sp_y       <= 5'd0;
      sp_len     <= 6'd0;
    end else begin
      state      <= state_next;
      rd_addr    <= rd_addr_next;
      rd_pend    <= rd_pend_next;
      hold_valid <= hold_valid_next;
      hold_data  <= hold_data_next;
      proc_cnt   <= proc_cnt_next;
      proc_done  <= proc_done_next;
      run_active <= run_active_next;
      run_tag    <= run_tag_next;
      run_x      <= run_x_next;
      run_y      <= run_y_next;
      run_len    <= run_len_next;
      tx         <= tx_next;
      ty         <= ty_next;
      sp_valid   <= sp_valid_next;
      sp_poly    <= sp_poly_next;
      sp_x       <= sp_x_next;
      sp_y       <= sp_y_next;
      sp_len     <= sp_len_next;
    end
  end

  assign busy           = (state == SCAN) || (state == FLUSH);
  assign done           = (state == DONE);
  assign tag_rd         = rd;
  assign tag_rd_addr    = rd_addr;
  assign span_valid     = sp_valid;
  assign span_poly_addr = sp_poly;
  assign span_x         = sp_x;
  assign span_y         = sp_y;
  assign span_len       = sp_len;
  assign span_tile_x    = tx;
  assign span_tile_y    = ty;

endmodule

// File: tb/tb_tile_tag_reader.sv
// Directed bench for tile_tag_reader: tag RAM model, span scoreboard and
// protocol monitor (no reads under stall, span fields stable under stall).
module tb_tile_tag_reader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  tile_x = 6'd7;
  logic [5:0]  tile_y = 6'd42;
  logic        busy, done, tag_rd, span_valid;
  logic        span_ready = 1'b1;
  logic [9:0]  tag_rd_addr;
  logic [31:0] tag_rd_data = 32'd0;
  logic [31:0] span_poly_addr;
  logic [4:0]  span_x, span_y;
  logic [5:0]  span_len, span_tile_x, span_tile_y;

  localparam logic [31:0] TAG_A = 32'hDEAD_0001;
  localparam logic [31:0] TAG_B = 32'h0BAD_F00D;

  tile_tag_reader dut (
    .clock(clock), .reset(reset), .start(start),
    .tile_x(tile_x), .tile_y(tile_y),
    .busy(busy), .done(done), .tag_rd(tag_rd), .tag_rd_addr(tag_rd_addr),
    .tag_rd_data(tag_rd_data),
    .span_valid(span_valid), .span_ready(span_ready),
    .span_poly_addr(span_poly_addr), .span_x(span_x), .span_y(span_y),
    .span_len(span_len), .span_tile_x(span_tile_x), .span_tile_y(span_tile_y)
  );

  always #5 clock = ~clock;

  logic [31:0] mem [0:1023];
  always @(posedge clock) if (tag_rd) tag_rd_data <= mem[tag_rd_addr];

  int n_checks = 0;
  int n_errors = 0;
  int cycle = 0;
  int rd_count, addr_bad, done_count, last_rd_cyc, done_cyc;
  logic        rnd_mode = 1'b0;
  logic        prev_stall = 1'b0;
  logic [59:0] prev_fields = 60'd0;
  logic [59:0] fields;
  logic [59:0] got_q[$];
  logic [59:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [59:0] mk(input logic [31:0] p, input int x, input int y, input int len);
    logic [4:0] xs, ys;
    logic [5:0] ls;
    xs = x[4:0];
    ys = y[4:0];
    ls = len[5:0];
    return {p, xs, ys, ls, tile_x, tile_y};
  endfunction

  always @(posedge clock) cycle <= cycle + 1;

  // Protocol monitor sampled mid-cycle.
  always @(negedge clock) begin
    fields = {span_poly_addr, span_x, span_y, span_len, span_tile_x, span_tile_y};
    if (!reset) begin
      if (tag_rd) begin
        if (tag_rd_addr != rd_count[9:0]) addr_bad++;
        rd_count++;
        last_rd_cyc = cycle;
      end
      if (done) begin
        done_count++;
        done_cyc = cycle;
        check("busy_at_done", {63'd0, busy}, 64'd0);
      end
      if (span_valid && span_ready) got_q.push_back(fields);
      if (span_valid && !span_ready) check("rd_in_stall", {63'd0, tag_rd}, 64'd0);
      if (prev_stall) check("span_stable", {4'd0, fields}, {4'd0, prev_fields});
    end
    prev_stall  = span_valid && !span_ready && !reset;
    prev_fields = fields;
  end

  initial forever begin
    @(posedge clock);
    #1;
    span_ready = rnd_mode ? ($urandom_range(0, 9) < 3) : 1'b1;
  end

  task automatic fill_const(input logic [31:0] v);
    for (int i = 0; i < 1024; i++) mem[i] = v;
  endtask

  task automatic fill_row5();
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    for (int x = 0; x < 32; x++) mem[5*32+x] = (x < 4) ? TAG_A : (x == 4) ? 32'd0 : (x < 10) ? TAG_A : TAG_B;
    exp_q.delete();
    exp_q.push_back(mk(TAG_A, 0, 5, 4));
    exp_q.push_back(mk(TAG_A, 5, 5, 5));
    exp_q.push_back(mk(TAG_B, 10, 5, 22));
  endtask

  task automatic fill_checker();
    exp_q.delete();
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 32; x++) begin
        mem[y*32+x] = ((x + y) % 2 == 0) ? TAG_A : TAG_B;
        exp_q.push_back(mk(((x + y) % 2 == 0) ? TAG_A : TAG_B, x, y, 1));
      end
  endtask

  task automatic run_scan(input string name, input int budget, input int restart_at);
    int n;
    got_q.delete();
    rd_count = 0; addr_bad = 0; done_count = 0; last_rd_cyc = 0; done_cyc = 0;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    n = 0;
    while (done_count == 0 && n < budget) begin
      start = (n == restart_at);
      @(posedge clock); #1;
      n++;
    end
    start = 1'b0;
    if (done_count == 0) check({name, "_timeout"}, 64'd0, 64'd1);
    repeat (4) @(posedge clock);
    #1;
    check({name, "_rd_count"}, rd_count, 1024);
    check({name, "_rd_order"}, addr_bad, 0);
    check({name, "_done_count"}, done_count, 1);
    check({name, "_nspans"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check({name, "_span"}, {4'd0, got_q[i]}, {4'd0, exp_q[i]});
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_tag_rd", {63'd0, tag_rd}, 64'd0);
    check("rst_span_valid", {63'd0, span_valid}, 64'd0);
    check("rst_addr", {54'd0, tag_rd_addr}, 64'd0);
    check("rst_span_fields", {4'd0, span_poly_addr, span_x, span_y, span_len, span_tile_x, span_tile_y}, 64'd0);

    // All-zero tile: no spans, done two cycles after the last read.
    fill_const(32'd0);
    exp_q.delete();
    run_scan("zero", 3000, -1);
    check("zero_done_lat", done_cyc - last_rd_cyc, 2);

    // Uniform tag: one full-row span per row.
    fill_const(32'h0000_1000);
    exp_q.delete();
    for (int y = 0; y < 32; y++) exp_q.push_back(mk(32'h0000_1000, 0, y, 32));
    run_scan("const", 3000, -1);

    fill_row5();
    run_scan("row5", 3000, -1);

    fill_checker();
    run_scan("chk", 3000, -1);
    rnd_mode = 1'b1;
    run_scan("chk_rnd", 40000, -1);
    rnd_mode = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    // Reset mid-scan at address 300, then an immediate restart.
    fill_row5();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    n = 0;
    while (tag_rd_addr != 10'd300 && n < 2000) begin
      @(posedge clock); #1;
      n++;
    end
    check("abort_reach_300", {54'd0, tag_rd_addr}, 64'd300);
    done_count = 0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_span_valid", {63'd0, span_valid}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_done_count", done_count, 0);
    run_scan("after_abort", 3000, -1);

    // Second start during SCAN is ignored.
    fill_row5();
    run_scan("restart", 3000, 50);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
